// File: rtl/m72_sample_dac.sv
// M72 sample-MCU DAC byte to signed 16-bit PCM, with an idle fade back to centre.
// Define M72_SAMPLE_LPF_EN to add a first-order IIR on the output.
module m72_sample_dac #(
    parameter int IDLE_TICKS = 4096,
    parameter int CNT_W      = 13,
    parameter int LPF_SHIFT  = 2
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        ce_out,
    input  logic [7:0]  sample_in,
    input  logic [3:0]  volume,
    output logic [15:0] sample_out,
    output logic        active
);

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        ACTIVE = 2'd1,
        FADE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(IDLE_TICKS - 1);
    localparam logic [7:0]       CENTRE = 8'h80;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       prev;
    logic [7:0]       held;
    logic [7:0]       held_nxt;
    logic [7:0]       held_step;
    logic [7:0]       src;
    logic [7:0]       s8;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             change;
    logic [11:0]      p;
    logic [15:0]      x16;
    logic [15:0]      out_nxt;

    if (CNT_W < 1 || CNT_W > 30 || (1 << CNT_W) <= IDLE_TICKS) begin : g_bad_cnt
        $error("m72_sample_dac: CNT_W too narrow for IDLE_TICKS");
    end
    if (LPF_SHIFT < 1 || LPF_SHIFT > 6) begin : g_bad_shift
        $error("m72_sample_dac: LPF_SHIFT out of range");
    end

    assign change = (sample_in != prev);

    always_comb begin
        held_step = held;
        if (held < CENTRE)
            held_step = held + 8'd1;
        else if (held > CENTRE)
            held_step = held - 8'd1;
    end

    // A fresh write always wins over the strobe-driven idle/fade bookkeeping
    always_comb begin
        state_nxt = state;
        if (change) begin
            state_nxt = ACTIVE;
        end else if (ce_out) begin
            unique case (state)
                ACTIVE:  if (idle_cnt == LAST) state_nxt = FADE;
                FADE:    if (held_step == CENTRE) state_nxt = SILENT;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        held_nxt = held;
        cnt_nxt  = idle_cnt;
        if (change) begin
            held_nxt = sample_in;
            cnt_nxt  = '0;
        end else if (ce_out) begin
            unique case (state)
                ACTIVE:  cnt_nxt  = (idle_cnt == LAST) ? '0 : idle_cnt + CNT_W'(1);
                FADE:    held_nxt = held_step;
                default: held_nxt = held;
            endcase
        end
    end

    // Offset-binary to two's complement, then linear gain
    assign src = change ? sample_in : held;
    assign s8  = {~src[7], src[6:0]};
    assign p   = {{4{s8[7]}}, s8} * {8'd0, volume};
    assign x16 = {p, 4'd0};

`ifdef M72_SAMPLE_LPF_EN
    logic [15:0] y;
    logic [15:0] y_nxt;

    assign y_nxt   = y + 16'(($signed({x16[15], x16}) - $signed({y[15], y})) >>> LPF_SHIFT);
    assign out_nxt = y_nxt;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset)
            y <= '0;
        else if (ce_out)
            y <= y_nxt;
    end
`else
    assign out_nxt = x16;
`endif

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state      <= SILENT;
            prev       <= CENTRE;
            held       <= CENTRE;
            idle_cnt   <= '0;
            sample_out <= '0;
            active     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= sample_in;
            held     <= held_nxt;
            idle_cnt <= cnt_nxt;
            active   <= (state != SILENT);
            if (ce_out)
                sample_out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_m72_sample_dac.sv
// Bench for m72_sample_dac: vector table, fade/reset sequences, random vs reference model.
// Model tracks quiet ticks since the last write rather than an explicit state machine.
module tb_m72_sample_dac;

    localparam int IDLE = 4096;
`ifdef M72_SAMPLE_LPF_EN
    localparam int SH = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_out = 1'b0;
    logic [7:0]  sample_in = 8'h80;
    logic [3:0]  volume = 4'd15;
    logic [15:0] sample_out;
    logic        active;

    int errors = 0;
    int checks = 0;

    int m_prev, m_held, m_quiet, m_out, m_y;
    bit m_play, m_act;

    typedef struct {
        logic [7:0] s;
        logic [3:0] v;
        bit         coin;
        int         exp;
    } vec_t;

    vec_t vt[11];
    logic [7:0] rs;
    int prev_y;
    int lpf_exp[3];

    m72_sample_dac #(.IDLE_TICKS(4096), .CNT_W(13), .LPF_SHIFT(2)) dut (
        .CLK_32M    (clk),
        .reset      (reset),
        .ce_out     (ce_out),
        .sample_in  (sample_in),
        .volume     (volume),
        .sample_out (sample_out),
        .active     (active)
    );

    always #5 clk = ~clk;

    function automatic int conv(input int h, input int v);
        return (h - 128) * v * 16;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 128;
        m_held  = 128;
        m_quiet = 0;
        m_play  = 0;
        m_out   = 0;
        m_y     = 0;
        m_act   = 0;
    endtask

    task automatic cyc(input logic [7:0] s, input logic [3:0] v, input logic ce);
        bit chg;
        int x;
        sample_in = s;
        volume    = v;
        ce_out    = ce;
        @(posedge clk);
        chg   = (int'(s) != m_prev);
        m_act = m_play;
        if (ce) begin
            x = conv(chg ? int'(s) : m_held, int'(v));
`ifdef M72_SAMPLE_LPF_EN
            m_y   = m_y + ((x - m_y) >>> SH);
            m_out = m_y;
`else
            m_out = x;
`endif
        end
        if (chg) begin
            m_held  = int'(s);
            m_quiet = 0;
            m_play  = 1;
        end else if (ce && m_play) begin
            m_quiet++;
            if (m_quiet > IDLE) begin
                if (m_held < 128) m_held++;
                else if (m_held > 128) m_held--;
                if (m_held == 128) m_play = 0;
            end
        end
        m_prev = int'(s);
        #1;
        chk("out", int'($signed(sample_out)), m_out);
        chk("active", int'(active), int'(m_act));
    endtask

    task automatic run_ticks(input int n, input logic [7:0] s, input logic [3:0] v, input int per);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < per - 1; j++) cyc(s, v, 1'b0);
            cyc(s, v, 1'b1);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sample_in = 8'h80;
        ce_out    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_out", int'($signed(sample_out)), 0);
        chk("rst_active", int'(active), 0);
        reset = 1'b0;
    endtask

    initial begin
        vt[0]  = '{8'hFF, 4'd15, 1'b0, 30480};
        vt[1]  = '{8'hFF, 4'd1,  1'b0, 2032};
        vt[2]  = '{8'hFF, 4'd0,  1'b0, 0};
        vt[3]  = '{8'h00, 4'd15, 1'b0, -30720};
        vt[4]  = '{8'h80, 4'd15, 1'b1, 0};
        vt[5]  = '{8'hC0, 4'd15, 1'b1, 15360};
        vt[6]  = '{8'h40, 4'd15, 1'b0, -15360};
        vt[7]  = '{8'h81, 4'd7,  1'b1, 112};
        vt[8]  = '{8'h7F, 4'd3,  1'b0, -48};
        vt[9]  = '{8'h3C, 4'd9,  1'b1, -9792};
        vt[10] = '{8'hFF, 4'd15, 1'b1, 30480};
        lpf_exp = '{7620, 13335, 17621};

        model_reset();
        do_reset();

        // Full idle timeout and fade from the bottom rail
        run_ticks(4096, 8'h00, 4'd15, 3);
        chk("pre_fade_out", int'($signed(sample_out)), -30720);
        chk("pre_fade_active", int'(active), 1);
        run_ticks(127, 8'h00, 4'd15, 3);
        run_ticks(1, 8'h00, 4'd15, 3);
        chk("last_fade_out", int'($signed(sample_out)), -240);
        chk("last_fade_active", int'(active), 1);
        cyc(8'h00, 4'd15, 1'b0);
        chk("silent_active", int'(active), 0);
        run_ticks(1, 8'h00, 4'd15, 3);
        chk("silent_out", int'($signed(sample_out)), 0);

        // Re-write restarts the idle count, then a write lands mid-fade on a strobe
        run_ticks(1000, 8'h3D, 4'd15, 3);
        run_ticks(4100, 8'h3C, 4'd15, 3);
        chk("fade_active", int'(active), 1);
        cyc(8'hC0, 4'd15, 1'b1);
        chk("midfade_write", int'($signed(sample_out)), 15360);
        chk("midfade_active", int'(active), 1);
        run_ticks(4098, 8'hC0, 4'd15, 3);
        chk("refade_out", int'($signed(sample_out)), 15120);

        // Asynchronous reset between edges while fading
        #2;
        reset = 1'b1;
        #1;
        chk("async_out", int'($signed(sample_out)), 0);
        chk("async_active", int'(active), 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        run_ticks(3, 8'h80, 4'd15, 572);
        chk("powerup_out", int'($signed(sample_out)), 0);
        chk("powerup_active", int'(active), 0);

`ifdef M72_SAMPLE_LPF_EN
        cyc(8'hFF, 4'd15, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_ticks(1, 8'hFF, 4'd15, 3);
            chk("lpf_step", int'($signed(sample_out)), lpf_exp[i]);
        end
        for (int i = 0; i < 37; i++) begin
            prev_y = int'($signed(sample_out));
            run_ticks(1, 8'hFF, 4'd15, 3);
            chk("lpf_mono", int'(int'($signed(sample_out)) >= prev_y), 1);
        end
        chk("lpf_conv", int'((30480 - int'($signed(sample_out))) inside {[0:3]}), 1);
`endif

        for (int i = 0; i < 11; i++) begin
            if (vt[i].coin) begin
                cyc(vt[i].s, vt[i].v, 1'b1);
            end else begin
                cyc(vt[i].s, vt[i].v, 1'b0);
                cyc(vt[i].s, vt[i].v, 1'b1);
            end
`ifndef M72_SAMPLE_LPF_EN
            chk("table_out", int'($signed(sample_out)), vt[i].exp);
`endif
            if (i == 0) chk("table_active", int'(active), 1);
        end

        rs = 8'h80;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)
                rs = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
            cyc(rs, 4'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m72_sample_dac.md
Name: m72_sample_dac

Overview:
- Downstream consumer of the 8051 sample MCU's 8-bit unsigned DAC port (P1), converting it to a signed 16-bit stream for the audio mixer.
- Holds the last written sample, applies a 4-bit volume, and updates the output only on an output-rate clock enable.
- When the MCU stops writing while the port rests off-centre, the block ramps the held value back to centre, so that playback stop does not leave a DC offset or cause a click.

Parameters:
IDLE_TICKS, 4096, number of ce_out ticks with no input change before the fade starts.
CNT_W, 13, idle counter width; must satisfy 2^CNT_W > IDLE_TICKS.
LPF_SHIFT, 2, IIR coefficient shift (1..6); used only when the optional feature is compiled in.

Ports:
CLK_32M  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
ce_out  input  1  single-cycle output-rate strobe, nominally 55.93 kHz.
sample_in  input  8  unsigned DAC byte from the MCU; 0x80 is silence.
volume  input  4  linear gain, 0 to 15; 0 gives silence.
sample_out  output  16  signed PCM, registered.
active  output  1  high while the state is ACTIVE or FADE.

Behaviour:
- Reset (asynchronous):
  - sample_out = 0, active = 0.
  - state = SILENT, held = 0x80, prev = 0x80, idle_cnt = 0, filter accumulator = 0.
  - Reset asserted mid-fade or mid-playback returns all of these values within the same cycle.
- Input sampling:
  - prev <= sample_in on every clock.
  - change = (sample_in != prev), evaluated every clock regardless of ce_out.
- States: SILENT, ACTIVE, FADE.
  - Any state, change = 1: held <= sample_in, idle_cnt <= 0, state <= ACTIVE. This has priority over every ce_out action in the same cycle.
  - ACTIVE, ce_out and no change:
    - If idle_cnt == IDLE_TICKS-1, state <= FADE and idle_cnt <= 0.
    - Otherwise idle_cnt <= idle_cnt + 1.
  - FADE, ce_out and no change:
    - held moves one LSB toward 0x80: +1 if held < 0x80, -1 if held > 0x80.
    - When the updated held equals 0x80, state <= SILENT.
    - A held value that is already 0x80 on FADE entry goes to SILENT on the first FADE tick.
  - SILENT: held stays at 0x80. The idle counter does not run.
- Conversion (combinational, from held):
  - s8 = {~held[7], held[6:0]} as signed 8.
  - p = s8 * volume as signed 12. The range is -1920..1905, so no saturation is needed.
  - x16 = p << 4, range -30720..30480.
- Output:
  - Updated only on ce_out: sample_out <= x16.
  - In a cycle with both change and ce_out, x16 is computed from the new sample_in, not the old held.
  - Latency is a write at cycle N appearing on sample_out at the first ce_out at or after N, registered one clock later.
  - Between ce_out strobes, sample_out is stable.
- active is registered and equals (state != SILENT) with one clock of latency.
- Input that toggles faster than ce_out: only the value present on the ce_out cycle is output, but every toggle still resets idle_cnt.
- volume is sampled combinationally on the ce_out cycle. No smoothing is applied.

Optional Feature:
- Macro: M72_SAMPLE_LPF_EN.
- With the macro defined:
  - A first-order IIR runs on ce_out with a signed 16-bit accumulator y: y <= y + ((x16 - y) >>> LPF_SHIFT).
  - The subtraction is computed at 17 bits; the shift is arithmetic.
  - sample_out <= the new y on the same ce_out, adding no extra clock of latency beyond the registered update.
  - Change-priority rules are unchanged. Reset clears y.
  - This approximates the analogue RC after the DAC.
- Without the macro: sample_out <= x16 directly, and the IIR logic is absent.

Test Plan:
- Reset release, sample_in = 0x80, volume = 15, ce_out every 572 clocks -> sample_out = 0 and active = 0 indefinitely.
- sample_in = 0xFF, volume = 15 -> active = 1 one clock after the change; at the next ce_out, sample_out = 0x7710 (30480). With volume = 1 -> 0x07F0. With volume = 0 -> 0.
- sample_in = 0x00, volume = 15, no further writes -> ACTIVE for 4096 ticks, then held ramps 0x00 to 0x80 over 128 ticks, output rising -30720 toward 0. State is SILENT after the 128th FADE tick; active drops one clock later.
- Mid-fade (held = 0x40) write of 0xC0 coincident with ce_out -> same-strobe sample_out reflects 0xC0 (+15360 at vol 15), state = ACTIVE, idle_cnt = 0.
- Asynchronous reset pulse mid-fade between clock edges -> sample_out = 0 and active = 0 immediately. After release, behaviour is as from power-up.
- M72_SAMPLE_LPF_EN, LPF_SHIFT = 2, step from 0x80 to 0xFF at vol 15 -> outputs 7620, 13335, 17621, ..., monotonic and converging to 30480 within 40 ticks.
